// File: rtl/clk_divider_multi.sv
// Multi-channel programmable clock divider with shadowed ratio registers.
// Optional phase-align strobe i_SYNC is built only when CLKDIV_SYNC_EN is defined.
module clk_divider_multi #(
   parameter  int CHANNELS    = 4,
   parameter  int WIDTH       = 8,
   parameter  int RESET_RATIO = 4,
   localparam int AW          = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                i_CLK,
   input  logic                i_RST_N,
   input  logic [CHANNELS-1:0] i_EN,
   input  logic                i_WE,
   input  logic [AW-1:0]       i_ADDR,
   input  logic [WIDTH-1:0]    i_RATIO,
`ifdef CLKDIV_SYNC_EN
   input  logic                i_SYNC,
`endif
   output logic [CHANNELS-1:0] o_CLK,
   output logic [CHANNELS-1:0] o_TICK,
   output logic [CHANNELS-1:0] o_PENDING
);

   localparam int               RST_EFF     = (RESET_RATIO < 2) ? 2 : RESET_RATIO;
   localparam logic [WIDTH-1:0] RST_RATIO_L = WIDTH'(RESET_RATIO);
   localparam logic [WIDTH-1:0] RST_CNT_L   = WIDTH'(RST_EFF - 1);
   localparam logic [WIDTH-1:0] ONE_L       = WIDTH'(1);
   localparam logic [WIDTH-1:0] TWO_L       = WIDTH'(2);
   localparam logic [WIDTH-1:0] ZERO_L      = {WIDTH{1'b0}};

   for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
      // Out-of-range addresses match no channel, so they are dropped here.
      localparam logic [AW-1:0] K_L = AW'(k);

      logic [WIDTH-1:0] active_r, shadow_r, cnt_r;
      logic             pending_r, clk_r, tick_r;
      logic [WIDTH-1:0] active_s, shadow_s, cnt_s, cnt_inc_s, r_eff_s, h_s;
      logic             pending_s, clk_s, tick_s, wrap_s, restart_s, wr_hit_s;

      // Next-state: count, wrap/restart with shadow apply, then register write.
      always_comb begin
         r_eff_s   = (active_r < TWO_L) ? TWO_L : active_r;
         h_s       = {1'b0, r_eff_s[WIDTH-1:1]} + {{(WIDTH-1){1'b0}}, r_eff_s[0]};
         wrap_s    = (cnt_r == (r_eff_s - ONE_L));
         cnt_inc_s = cnt_r + ONE_L;
         wr_hit_s  = i_WE && (i_ADDR == K_L);
`ifdef CLKDIV_SYNC_EN
         restart_s = wrap_s || i_SYNC;
`else
         restart_s = wrap_s;
`endif
         active_s  = active_r;
         shadow_s  = shadow_r;
         pending_s = pending_r;
         cnt_s     = cnt_r;
         clk_s     = clk_r;
         tick_s    = 1'b0;
         if (i_EN[k]) begin
            if (restart_s) begin
               cnt_s  = ZERO_L;
               clk_s  = 1'b1;
               tick_s = 1'b1;
               if (pending_r) begin
                  active_s  = shadow_r;
                  pending_s = 1'b0;
               end else begin
                  active_s  = active_r;
               end
            end else begin
               cnt_s  = cnt_inc_s;
               clk_s  = (cnt_inc_s < h_s);
               tick_s = 1'b0;
            end
         end else begin
            cnt_s  = cnt_r;
            clk_s  = clk_r;
            tick_s = 1'b0;
         end
         // A write in the apply cycle lands after the old shadow was consumed.
         if (wr_hit_s) begin
            shadow_s  = i_RATIO;
            pending_s = 1'b1;
         end else begin
            shadow_s  = shadow_r;
         end
      end

      // Channel state and registered outputs.
      always_ff @(posedge i_CLK or negedge i_RST_N) begin
         if (!i_RST_N) begin
            active_r  <= RST_RATIO_L;
            shadow_r  <= RST_RATIO_L;
            pending_r <= 1'b0;
            cnt_r     <= RST_CNT_L;
            clk_r     <= 1'b0;
            tick_r    <= 1'b0;
         end else begin
            active_r  <= active_s;
            shadow_r  <= shadow_s;
            pending_r <= pending_s;
            cnt_r     <= cnt_s;
            clk_r     <= clk_s;
            tick_r    <= tick_s;
         end
      end

      assign o_CLK[k]     = clk_r;
      assign o_TICK[k]    = tick_r;
      assign o_PENDING[k] = pending_r;
   end

endmodule

// File: tb/tb_clk_divider_multi.sv
// Directed self-checking bench for clk_divider_multi (5 channels, so address 5 is out of range).
module tb_clk_divider_multi;
   localparam int N = 5;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [N-1:0] en = {N{1'b1}};
   logic         we = 1'b0;
   logic [2:0]   addr = 3'd0;
   logic [7:0]   ratio = 8'd0;
`ifdef CLKDIV_SYNC_EN
   logic         sync = 1'b0;
`endif
   logic [N-1:0] o_clk, o_tick, o_pend;

   int n_cmp = 0;
   int n_bad = 0;

   clk_divider_multi #(.CHANNELS(N), .WIDTH(8), .RESET_RATIO(4)) dut (
      .i_CLK(clk), .i_RST_N(rst_n), .i_EN(en), .i_WE(we), .i_ADDR(addr), .i_RATIO(ratio),
`ifdef CLKDIV_SYNC_EN
      .i_SYNC(sync),
`endif
      .o_CLK(o_clk), .o_TICK(o_tick), .o_PENDING(o_pend)
   );

   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic wr(input logic [2:0] a, input logic [7:0] r);
      we = 1'b1; addr = a; ratio = r;
      cyc();
      we = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; en = {N{1'b1}}; we = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      logic e;
      rst_n = 1'b0; en = {N{1'b1}};
      repeat (2) @(negedge clk);
      n_cmp++;
      if ({o_clk, o_tick, o_pend} !== {3*N{1'b0}}) begin
         n_bad++; $display("FAIL reset_outputs got=%b exp=0", {o_clk, o_tick, o_pend});
      end
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         cyc();
         e = ((i % 4) < 2);
         n_cmp++;
         if (o_clk !== {N{e}}) begin
            n_bad++; $display("FAIL reset_clk cyc=%0d got=%b exp=%b", i, o_clk, {N{e}});
         end
         e = ((i % 4) == 0);
         n_cmp++;
         if (o_tick !== {N{e}}) begin
            n_bad++; $display("FAIL reset_tick cyc=%0d got=%b exp=%b", i, o_tick, {N{e}});
         end
      end
   endtask

   task automatic test_odd_ratio();
      logic e;
      do_reset();
      cyc();
      wr(3'd1, 8'd5);
      for (int i = 0; i < 2; i++) begin
         n_cmp++;
         if (o_pend[1] !== 1'b1) begin
            n_bad++; $display("FAIL odd_pending_hi step=%0d got=%b exp=1", i, o_pend[1]);
         end
         cyc();
      end
      for (int i = 0; i < 10; i++) begin
         cyc();
         if (i == 0) begin
            n_cmp++;
            if (o_pend[1] !== 1'b0) begin
               n_bad++; $display("FAIL odd_pending_lo got=%b exp=0", o_pend[1]);
            end
         end
         e = ((i % 5) < 3);
         n_cmp++;
         if (o_clk[1] !== e) begin
            n_bad++; $display("FAIL odd_clk cyc=%0d got=%b exp=%b", i, o_clk[1], e);
         end
         e = ((i % 5) == 0);
         n_cmp++;
         if (o_tick[1] !== e) begin
            n_bad++; $display("FAIL odd_tick cyc=%0d got=%b exp=%b", i, o_tick[1], e);
         end
      end
   endtask

   task automatic test_mid_period();
      logic e;
      do_reset();
      cyc();
      cyc();
      wr(3'd2, 8'd6);
      n_cmp++;
      if ({o_clk[2], o_pend[2]} !== 2'b01) begin
         n_bad++; $display("FAIL mid_old_period got=%b exp=01", {o_clk[2], o_pend[2]});
      end
      cyc();
      n_cmp++;
      if (o_clk[2] !== 1'b0) begin
         n_bad++; $display("FAIL mid_old_low got=%b exp=0", o_clk[2]);
      end
      for (int i = 0; i < 12; i++) begin
         cyc();
         e = ((i % 6) < 3);
         n_cmp++;
         if (o_clk[2] !== e) begin
            n_bad++; $display("FAIL mid_clk cyc=%0d got=%b exp=%b", i, o_clk[2], e);
         end
      end
   endtask

   task automatic test_clamp();
      logic e;
      do_reset();
      wr(3'd3, 8'd0);
      wr(3'd0, 8'd1);
      cyc();
      cyc();
      for (int i = 0; i < 6; i++) begin
         cyc();
         e = ((i % 2) == 0);
         n_cmp++;
         if ({o_clk[3], o_clk[0]} !== {e, e}) begin
            n_bad++; $display("FAIL clamp_clk cyc=%0d got=%b exp=%b", i, {o_clk[3], o_clk[0]}, {e, e});
         end
         n_cmp++;
         if ({o_tick[3], o_tick[0]} !== {e, e}) begin
            n_bad++; $display("FAIL clamp_tick cyc=%0d got=%b exp=%b", i, {o_tick[3], o_tick[0]}, {e, e});
         end
      end
   endtask

   task automatic test_last_write();
      logic e;
      do_reset();
      wr(3'd1, 8'd7);
      wr(3'd1, 8'd9);
      wr(3'd5, 8'd3);
      n_cmp++;
      if (o_pend !== 5'b00010) begin
         n_bad++; $display("FAIL lw_pending got=%b exp=00010", o_pend);
      end
      cyc();
      for (int i = 0; i < 18; i++) begin
         cyc();
         e = ((i % 9) < 5);
         n_cmp++;
         if (o_clk[1] !== e) begin
            n_bad++; $display("FAIL lw_clk cyc=%0d got=%b exp=%b", i, o_clk[1], e);
         end
         e = ((i % 4) < 2);
         n_cmp++;
         if (o_clk[4] !== e) begin
            n_bad++; $display("FAIL lw_other_clk cyc=%0d got=%b exp=%b", i, o_clk[4], e);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic e;
      do_reset();
      wr(3'd0, 8'd6);
      cyc();
      cyc();
      cyc();
      wr(3'd0, 8'd3);
      n_cmp++;
      if ({o_pend[0], o_clk[0], o_tick[0]} !== 3'b111) begin
         n_bad++; $display("FAIL b2b_apply got=%b exp=111", {o_pend[0], o_clk[0], o_tick[0]});
      end
      for (int i = 1; i < 6; i++) begin
         cyc();
         e = (i < 3);
         n_cmp++;
         if (o_clk[0] !== e) begin
            n_bad++; $display("FAIL b2b_r6_clk cyc=%0d got=%b exp=%b", i, o_clk[0], e);
         end
      end
      for (int i = 0; i < 6; i++) begin
         cyc();
         if (i == 0) begin
            n_cmp++;
            if (o_pend[0] !== 1'b0) begin
               n_bad++; $display("FAIL b2b_pending got=%b exp=0", o_pend[0]);
            end
         end
         e = ((i % 3) < 2);
         n_cmp++;
         if (o_clk[0] !== e) begin
            n_bad++; $display("FAIL b2b_r3_clk cyc=%0d got=%b exp=%b", i, o_clk[0], e);
         end
      end
   endtask

   task automatic test_enable_freeze();
      do_reset();
      cyc();
      en[0] = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cyc();
         n_cmp++;
         if ({o_clk[0], o_tick[0]} !== 2'b10) begin
            n_bad++; $display("FAIL frz_hold cyc=%0d got=%b exp=10", i, {o_clk[0], o_tick[0]});
         end
         if (i == 1) begin
            n_cmp++;
            if (o_clk[1] !== 1'b0) begin
               n_bad++; $display("FAIL frz_other got=%b exp=0", o_clk[1]);
            end
         end
      end
      en[0] = 1'b1;
      cyc();
      n_cmp++;
      if (o_clk[0] !== 1'b1) begin
         n_bad++; $display("FAIL frz_high5 got=%b exp=1", o_clk[0]);
      end
      cyc();
      n_cmp++;
      if (o_clk[0] !== 1'b0) begin
         n_bad++; $display("FAIL frz_low got=%b exp=0", o_clk[0]);
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      wr(3'd2, 8'd7);
      n_cmp++;
      if ({o_clk[0], o_pend[2]} !== 2'b11) begin
         n_bad++; $display("FAIL ar_pre got=%b exp=11", {o_clk[0], o_pend[2]});
      end
      #2 rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({o_clk, o_tick, o_pend} !== {3*N{1'b0}}) begin
         n_bad++; $display("FAIL ar_clear got=%b exp=0", {o_clk, o_tick, o_pend});
      end
      @(negedge clk);
      rst_n = 1'b1;
      cyc();
      n_cmp++;
      if ({o_clk, o_tick} !== {2*N{1'b1}}) begin
         n_bad++; $display("FAIL ar_restart got=%b exp=all1", {o_clk, o_tick});
      end
   endtask

`ifdef CLKDIV_SYNC_EN
   task automatic test_sync();
      logic [1:0] e;
      do_reset();
      wr(3'd1, 8'd6);
      repeat (5) cyc();
      sync = 1'b1;
      cyc();
      sync = 1'b0;
      n_cmp++;
      if ({o_clk[1:0], o_tick[1:0]} !== 4'b1111) begin
         n_bad++; $display("FAIL sync_align got=%b exp=1111", {o_clk[1:0], o_tick[1:0]});
      end
      for (int i = 1; i <= 12; i++) begin
         cyc();
         e = {((i % 6) == 0), ((i % 4) == 0)};
         n_cmp++;
         if (o_tick[1:0] !== e) begin
            n_bad++; $display("FAIL sync_tick cyc=%0d got=%b exp=%b", i, o_tick[1:0], e);
         end
      end
   endtask
`endif

   initial begin
      test_reset();
      test_odd_ratio();
      test_mid_period();
      test_clamp();
      test_last_write();
      test_back_to_back();
      test_enable_freeze();
      test_async_reset();
`ifdef CLKDIV_SYNC_EN
      test_sync();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
